// File: rtl/dcache_pkg.sv
// Shared geometry constants and FSM state encoding for the write-back data cache.
package dcache_pkg;

  localparam int TAG_LEN           = 2;
  localparam int INDEX_ADDR_LEN    = 6;
  localparam int LINEWORD_ADDR_LEN = 2;
  localparam int MEM_ADDR_LEN      = TAG_LEN + INDEX_ADDR_LEN;
  localparam int ADDR_LEN          = MEM_ADDR_LEN + LINEWORD_ADDR_LEN + 2;
  localparam int LINEWORD_SIZE     = 1 << LINEWORD_ADDR_LEN;
  localparam int LINE_W            = 32 * LINEWORD_SIZE;
  localparam int NUM_LINES         = 1 << INDEX_ADDR_LEN;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WB,
    RF,
    RESP
  } state_e;

endpackage

// File: rtl/dcache_wb_ctrl_if.sv
// CPU load/store port plus line-level memory port of the data cache.
interface dcache_wb_ctrl_if;
  import dcache_pkg::*;

  logic                    cpu_req;
  logic                    cpu_we;
  logic [ADDR_LEN-1:0]     cpu_addr;
  logic [31:0]             cpu_wdata;
  logic [31:0]             cpu_rdata;
  logic                    cpu_ready;
  logic                    handshake;
  logic [LINE_W-1:0]       MemToCache_rd_line;
  logic [LINE_W-1:0]       CacheToMem_wr_line;
  logic                    wr_req;
  logic                    rd_req;
  logic [MEM_ADDR_LEN-1:0] mem_addr;

  // master is the cache controller; slave is the CPU/memory environment
  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, handshake, MemToCache_rd_line,
    output cpu_rdata, cpu_ready, CacheToMem_wr_line, wr_req, rd_req, mem_addr
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, handshake, MemToCache_rd_line,
    input  cpu_rdata, cpu_ready, CacheToMem_wr_line, wr_req, rd_req, mem_addr
  );

endinterface

// File: rtl/dcache_line_store.sv
// Tag/valid/dirty/data arrays: async read by index, sync word or line write.
module dcache_line_store
  import dcache_pkg::*;
(
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [INDEX_ADDR_LEN-1:0]    idx_i,
  output logic [TAG_LEN-1:0]           tag_o,
  output logic                         valid_o,
  output logic                         dirty_o,
  output logic [LINE_W-1:0]            line_o,
  input  logic                         word_we_i,
  input  logic [LINEWORD_ADDR_LEN-1:0] word_sel_i,
  input  logic [31:0]                  word_data_i,
  input  logic                         line_we_i,
  input  logic [TAG_LEN-1:0]           line_tag_i,
  input  logic [LINE_W-1:0]            line_data_i
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_LEN-1:0]   tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (word_we_i) begin
      dirty_q[idx_i] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays carry no reset; valid gates every use, so they map to plain RAM.
  always_ff @(posedge clk) begin
    if (line_we_i) begin
      tag_q[idx_i]  <= line_tag_i;
      data_q[idx_i] <= line_data_i;
    end else if (word_we_i) begin
      data_q[idx_i][32*word_sel_i +: 32] <= word_data_i;
    end
  end

  assign tag_o   = tag_q[idx_i];
  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign line_o  = data_q[idx_i];

endmodule

// File: rtl/dcache_wb_ctrl.sv
// Direct-mapped write-back/write-allocate cache controller with registered memory port.
module dcache_wb_ctrl
  import dcache_pkg::*;
(
  input  logic                   clk,
  input  logic                   rstn,
  dcache_wb_ctrl_if.master       bus,
  output logic [31:0]            hit_count,
  output logic [31:0]            miss_count
);

  state_e                  state_q, state_d;
  logic [ADDR_LEN-1:2]     addr_q, addr_d;
  logic                    we_q, we_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    relookup_q, relookup_d;
  logic                    cpu_ready_q, cpu_ready_d;
  logic                    wr_req_q, wr_req_d;
  logic                    rd_req_q, rd_req_d;
  logic [MEM_ADDR_LEN-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]             cpu_rdata_q, cpu_rdata_d;
  logic [LINE_W-1:0]       wr_line_q, wr_line_d;
  logic [31:0]             hit_q, hit_d;
  logic [31:0]             miss_q, miss_d;

  logic [TAG_LEN-1:0]           tag;
  logic [INDEX_ADDR_LEN-1:0]    idx;
  logic [LINEWORD_ADDR_LEN-1:0] word;
  logic [TAG_LEN-1:0]           st_tag;
  logic                         st_valid, st_dirty, hit;
  logic [LINE_W-1:0]            st_line;
  logic                         word_we, line_we;

  assign tag  = addr_q[ADDR_LEN-1 -: TAG_LEN];
  assign idx  = addr_q[ADDR_LEN-TAG_LEN-1 -: INDEX_ADDR_LEN];
  assign word = addr_q[2 +: LINEWORD_ADDR_LEN];
  assign hit  = st_valid && (st_tag == tag);

  dcache_line_store u_store (
    .clk         (clk),
    .rstn        (rstn),
    .idx_i       (idx),
    .tag_o       (st_tag),
    .valid_o     (st_valid),
    .dirty_o     (st_dirty),
    .line_o      (st_line),
    .word_we_i   (word_we),
    .word_sel_i  (word),
    .word_data_i (wdata_q),
    .line_we_i   (line_we),
    .line_tag_i  (tag),
    .line_data_i (bus.MemToCache_rd_line)
  );

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    relookup_d  = relookup_q;
    cpu_ready_d = 1'b0;
    wr_req_d    = wr_req_q;
    rd_req_d    = rd_req_q;
    mem_addr_d  = mem_addr_q;
    cpu_rdata_d = cpu_rdata_q;
    wr_line_d   = wr_line_q;
    hit_d       = hit_q;
    miss_d      = miss_q;
    word_we     = 1'b0;
    line_we     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.cpu_req) begin
          addr_d     = bus.cpu_addr[ADDR_LEN-1:2];
          we_d       = bus.cpu_we;
          wdata_d    = bus.cpu_wdata;
          relookup_d = 1'b0;
          state_d    = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          if (!relookup_q) hit_d = hit_q + 32'd1;
          if (we_q) begin
            word_we     = 1'b1;
            cpu_rdata_d = wdata_q;
          end else begin
            cpu_rdata_d = st_line[32*word +: 32];
          end
          cpu_ready_d = 1'b1;
          state_d     = RESP;
        end else begin
          if (!relookup_q) miss_d = miss_q + 32'd1;
          if (st_valid && st_dirty) begin
            wr_req_d   = 1'b1;
            mem_addr_d = {st_tag, idx};
            wr_line_d  = st_line;
            state_d    = WB;
          end else begin
            rd_req_d   = 1'b1;
            mem_addr_d = {tag, idx};
            state_d    = RF;
          end
        end
      end
      WB: begin
        if (bus.handshake) begin
          wr_req_d   = 1'b0;
          rd_req_d   = 1'b1;
          mem_addr_d = {tag, idx};
          state_d    = RF;
        end
      end
      RF: begin
        if (bus.handshake) begin
          line_we    = 1'b1;
          rd_req_d   = 1'b0;
          relookup_d = 1'b1;
          state_d    = LOOKUP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      relookup_q  <= 1'b0;
      cpu_ready_q <= 1'b0;
      wr_req_q    <= 1'b0;
      rd_req_q    <= 1'b0;
      mem_addr_q  <= '0;
      cpu_rdata_q <= '0;
      wr_line_q   <= '0;
      hit_q       <= '0;
      miss_q      <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      relookup_q  <= relookup_d;
      cpu_ready_q <= cpu_ready_d;
      wr_req_q    <= wr_req_d;
      rd_req_q    <= rd_req_d;
      mem_addr_q  <= mem_addr_d;
      cpu_rdata_q <= cpu_rdata_d;
      wr_line_q   <= wr_line_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
    end
  end

  assign bus.cpu_ready          = cpu_ready_q;
  assign bus.cpu_rdata          = cpu_rdata_q;
  assign bus.wr_req             = wr_req_q;
  assign bus.rd_req             = rd_req_q;
  assign bus.mem_addr           = mem_addr_q;
  assign bus.CacheToMem_wr_line = wr_line_q;
  assign hit_count              = hit_q;
  assign miss_count             = miss_q;

endmodule

// File: tb/tb_dcache_wb_ctrl.sv
// Self-checking bench: directed scenarios then random load/store traffic against a cache model.
module tb_dcache_wb_ctrl;

  logic        clk;
  logic        rstn;
  logic [31:0] hit_count, miss_count;

  dcache_wb_ctrl_if bus ();

  dcache_wb_ctrl dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (bus),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit           is_wr;
    logic [7:0]   addr;
    logic [127:0] line;
  } xfer_t;

  int errors = 0;
  int checks = 0;
  int op_n   = 0;

  // memory-side environment state (written only by the responder process)
  logic [127:0] mem_line [256];
  xfer_t        xq[$];
  int           wr_cyc = 0, rd_cyc = 0, viol = 0, stray_seen = 0;

  // controls written only by the main process
  bit hold_rd = 0, stray_on_ready = 0;
  int stray_pulse = 0;

  // behavioural model: CPU-visible word contents plus resident-line bookkeeping
  logic [31:0] ref_word [1024];
  bit          mv [64];
  bit          md [64];
  logic [1:0]  mt [64];
  logic [31:0] exp_hits, exp_misses;

  function automatic logic [31:0] init_word(int a, int i);
    if (a == 1 && i == 0) return 32'h1111_1111;
    return 32'hA000_0003 | 32'(a << 8) | 32'(i << 4);
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s op=%0d: got %0h expected %0h", tag, op_n, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      mv[i] = 0;
      md[i] = 0;
    end
    for (int w = 0; w < 1024; w++) ref_word[w] = mem_line[w >> 2][32*(w & 3) +: 32];
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  // Memory responder and protocol monitor, evaluated once per cycle on the falling edge.
  initial begin
    bit           busy = 0, prev_hs = 0, prev_wr = 0, prev_rd = 0;
    int           cnt = 0;
    logic [7:0]   prev_addr = '0;
    logic [127:0] prev_line = '0;
    for (int a = 0; a < 256; a++)
      for (int i = 0; i < 4; i++) mem_line[a][32*i +: 32] = init_word(a, i);
    bus.handshake          = 1'b0;
    bus.MemToCache_rd_line = '0;
    forever begin
      @(negedge clk);
      bus.handshake = 1'b0;
      if (!rstn) begin
        busy    = 0;
        prev_hs = 0;
        prev_wr = 0;
        prev_rd = 0;
        continue;
      end
      if (bus.wr_req && bus.rd_req) viol++;
      if (prev_hs && prev_wr && bus.wr_req) viol++;
      if (prev_hs && prev_rd && bus.rd_req) viol++;
      if (bus.wr_req && prev_wr && !prev_hs &&
          (bus.mem_addr != prev_addr || bus.CacheToMem_wr_line != prev_line)) viol++;
      if (bus.rd_req && prev_rd && !prev_hs && bus.mem_addr != prev_addr) viol++;
      if (bus.wr_req) wr_cyc++;
      if (bus.rd_req) rd_cyc++;
      if (bus.wr_req || (bus.rd_req && !hold_rd)) begin
        if (!busy) begin
          busy = 1;
          cnt  = $urandom_range(0, 2);
        end
        if (cnt == 0) begin
          bus.handshake = 1'b1;
          busy = 0;
          if (bus.wr_req) begin
            mem_line[bus.mem_addr] = bus.CacheToMem_wr_line;
            xq.push_back('{1'b1, bus.mem_addr, bus.CacheToMem_wr_line});
          end else begin
            bus.MemToCache_rd_line = mem_line[bus.mem_addr];
            xq.push_back('{1'b0, bus.mem_addr, '0});
          end
        end else begin
          cnt--;
        end
      end
      if (stray_pulse != stray_seen) begin
        bus.handshake = 1'b1;
        stray_seen    = stray_pulse;
      end
      if (stray_on_ready && bus.cpu_ready) bus.handshake = 1'b1;
      prev_hs   = bus.handshake;
      prev_wr   = bus.wr_req;
      prev_rd   = bus.rd_req;
      prev_addr = bus.mem_addr;
      prev_line = bus.CacheToMem_wr_line;
    end
  end

  task automatic do_op(input bit we, input logic [11:0] addr, input logic [31:0] wd);
    logic [5:0]   idx = addr[9:4];
    logic [1:0]   tag = addr[11:10];
    bit           exp_hit, exp_dirty;
    logic [7:0]   victim;
    logic [127:0] wb_line;
    logic [31:0]  exp_data;
    int           x0, wc0, rc0, n, nx, exp_n, k;
    op_n++;
    exp_hit   = mv[idx] && (mt[idx] == tag);
    exp_dirty = !exp_hit && mv[idx] && md[idx];
    victim    = {mt[idx], idx};
    for (int i = 0; i < 4; i++) wb_line[32*i +: 32] = ref_word[{victim, 2'(i)}];
    exp_data  = we ? wd : ref_word[addr[11:2]];
    x0  = xq.size();
    wc0 = wr_cyc;
    rc0 = rd_cyc;
    @(negedge clk);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.cpu_ready && n < 60);
    bus.cpu_req = 1'b0;
    check("ready_seen", bus.cpu_ready, 1'b1);
    check("rdata", bus.cpu_rdata, exp_data);
    if (exp_hit) check("hit_latency", n, 2);
    else         check("miss_latency", n, 3 + (wr_cyc - wc0) + (rd_cyc - rc0));
    if (exp_hit) exp_hits++;
    else         exp_misses++;
    check("hit_count", hit_count, exp_hits);
    check("miss_count", miss_count, exp_misses);
    nx    = xq.size() - x0;
    exp_n = exp_hit ? 0 : (exp_dirty ? 2 : 1);
    check("xfer_count", nx, exp_n);
    if (nx == exp_n && exp_n > 0) begin
      k = x0;
      if (exp_dirty) begin
        check("wb_kind", xq[k].is_wr, 1'b1);
        check("wb_addr", xq[k].addr, victim);
        check("wb_line", xq[k].line, wb_line);
        k++;
      end
      check("rf_kind", xq[k].is_wr, 1'b0);
      check("rf_addr", xq[k].addr, {tag, idx});
    end
    if (!exp_hit) begin
      mv[idx] = 1;
      md[idx] = 0;
      mt[idx] = tag;
    end
    if (we) begin
      ref_word[addr[11:2]] = wd;
      md[idx] = 1;
    end
    @(negedge clk);
    check("ready_pulse", bus.cpu_ready, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rstn          = 1'b0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    #1;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_cpu_ready", bus.cpu_ready, 1'b0);
    check("rst_wr_req", bus.wr_req, 1'b0);
    check("rst_rd_req", bus.rd_req, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 8'h00);
    check("rst_cpu_rdata", bus.cpu_rdata, 32'h0);
    check("rst_hit_count", hit_count, 32'h0);
    check("rst_miss_count", miss_count, 32'h0);
    rstn = 1'b1;
    @(negedge clk);

    // cold load, hit store, read back, dirty eviction, clean eviction
    do_op(1'b0, 12'h010, 32'h0);
    check("cold_word0", ref_word[12'h010 >> 2], 32'h1111_1111);
    do_op(1'b1, 12'h014, 32'hDEAD_BEEF);
    do_op(1'b0, 12'h014, 32'h0);
    do_op(1'b0, 12'h410, 32'h0);
    check("wb_mem_word", mem_line[8'h01][63:32], 32'hDEAD_BEEF);
    do_op(1'b0, 12'h810, 32'h0);

    // stray handshakes in IDLE and RESP change nothing
    stray_pulse++;
    repeat (3) @(negedge clk);
    check("stray_idle_rd", bus.rd_req, 1'b0);
    check("stray_idle_wr", bus.wr_req, 1'b0);
    check("stray_idle_hits", hit_count, exp_hits);
    stray_on_ready = 1;
    do_op(1'b0, 12'h814, 32'h0);
    stray_on_ready = 0;
    do_op(1'b0, 12'h818, 32'h0);

    // reset while a refill is outstanding
    hold_rd = 1;
    @(negedge clk);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 12'hC10;
    k = 0;
    while (!bus.rd_req && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("rf_reached", bus.rd_req, 1'b1);
    rstn = 1'b0;
    #1;
    check("midrst_rd_req", bus.rd_req, 1'b0);
    check("midrst_cpu_ready", bus.cpu_ready, 1'b0);
    check("midrst_hits", hit_count, 32'h0);
    check("midrst_misses", miss_count, 32'h0);
    bus.cpu_req = 1'b0;
    hold_rd     = 0;
    repeat (2) @(negedge clk);
    model_reset();
    rstn = 1'b1;
    @(negedge clk);
    do_op(1'b0, 12'h010, 32'h0);

    // random traffic over a few conflicting indices
    for (int i = 0; i < 200; i++) begin
      logic [11:0] a;
      a = {2'($urandom_range(0, 3)), 3'b000, 3'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      do_op(1'($urandom_range(0, 1)), a, $urandom);
    end

    check("protocol_violations", viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
